fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 95 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the fetch PC and the IF/ID pipeline register.
// It also handles stall and redirect (jump/branch) and counts consecutive stall cycles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [7:0]  STALL_LIMIT = 8'd4
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        stall,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        jump,
    input  logic [31:0] PCJumpD,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        validD,
    output logic [7:0]  stall_cnt,
    output logic        stall_timeout
);

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;
    logic        timeout_q, timeout_d;

    logic [31:0] pcplus4_f;
    logic [31:0] target;
    logic        redirect;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pcplus4_f = pcf_q + 32'd4;
        redirect  = jump | PCSrcD;
        target    = (jump ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;

        pcf_d     = pcf_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;

        // Stall beats redirect; decode keeps presenting the redirect until the stall drops.
        if (!stall) begin
            if (redirect) begin
                pcf_d     = target;
                instr_d   = NOP;
                pcplus4_d = 32'h0;
                valid_d   = 1'b0;
            end else begin
                pcf_d     = pcplus4_f;
                instr_d   = imem_rdata;
                pcplus4_d = pcplus4_f;
                valid_d   = 1'b1;
            end
        end

        stall_cnt_d = 8'd0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
        end
        timeout_d = (stall_cnt_d >= STALL_LIMIT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pcf_q       <= RESET_PC;
            instr_q     <= NOP;
            pcplus4_q   <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            pcf_q       <= pcf_d;
            instr_q     <= instr_d;
            pcplus4_q   <= pcplus4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign imem_addr     = pcf_q;
    assign InstrD        = instr_q;
    assign PCPlus4D      = pcplus4_q;
    assign validD        = valid_q;
    assign stall_cnt     = stall_cnt_q;
    assign stall_timeout = timeout_q;

endmodule
